// File: rtl/dsi_hs_lane_tx.sv
// dsi_hs_lane_tx: D-PHY data-lane transmitter (LP->HS entry, LSB-first serialiser, HS-trail, LP-11 exit)
module dsi_hs_lane_tx #(
  parameter int T_LPX   = 2,
  parameter int T_PREP  = 3,
  parameter int T_ZERO  = 6,
  parameter int T_TRAIL = 4,
  parameter int CNT_W   = 8
) (
  input  logic       dsi_clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic       hs_en,
  output logic       hs_bit,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic       busy,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT} state_t;
  localparam logic [7:0] SYNC_W = 8'hB8;
  state_t state, n_state;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic [2:0] idx, n_idx;
  logic [7:0] sh, n_sh;
  logic last_f, n_last, tb, n_tb, n_ur;
  logic n_ready, n_hs_en, n_hs_bit, n_dp, n_dn, n_busy;
  always_comb begin
    n_state = state;
    n_cnt = cnt + 1'b1;
    n_idx = idx;
    n_sh = sh;
    n_last = last_f;
    n_tb = tb;
    n_ur = 1'b0;
    case (state)
      IDLE: begin
        n_cnt = '0;
        if (byte_valid && byte_ready) begin
          n_state = LPX;
          n_sh = byte_data;
          n_last = byte_last;
        end
      end
      LPX: if (cnt == CNT_W'(T_LPX - 1)) begin
        n_state = PREP;
        n_cnt = '0;
      end
      PREP: if (cnt == CNT_W'(T_PREP - 1)) begin
        n_state = ZERO;
        n_cnt = '0;
      end
      ZERO: if (cnt == CNT_W'(T_ZERO - 1)) begin
        n_state = SYNC;
        n_cnt = '0;
        n_idx = '0;
      end
      SYNC: begin
        n_idx = idx + 1'b1;
        if (idx == 3'd7) n_state = DATA;
      end
      DATA: begin
        n_idx = idx + 1'b1;
        if (idx == 3'd7) begin
          n_tb = ~sh[7];
          if (byte_valid && byte_ready) begin
            n_sh = byte_data;
            n_last = byte_last;
          end else begin
            n_state = TRAIL;
            n_cnt = '0;
            n_ur = !last_f;
          end
        end
      end
      TRAIL: if (cnt == CNT_W'(T_TRAIL - 1)) begin
        n_state = EXIT;
        n_cnt = '0;
      end
      EXIT: n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they register in the same edge as the state
  always_comb begin
    n_hs_en = n_state inside {ZERO, SYNC, DATA, TRAIL};
    n_hs_bit = n_state == SYNC ? SYNC_W[n_idx] :
               n_state == DATA ? n_sh[n_idx] :
               n_state == TRAIL ? n_tb : 1'b0;
    n_dp = n_state inside {IDLE, EXIT};
    n_dn = n_state inside {IDLE, EXIT, LPX};
    n_busy = n_state != IDLE;
    n_ready = n_state == IDLE || (n_state == DATA && n_idx == 3'd7 && !n_last);
  end
  always_ff @(posedge dsi_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      last_f <= 1'b0;
      tb <= 1'b0;
      byte_ready <= 1'b0;
      hs_en <= 1'b0;
      hs_bit <= 1'b0;
      lp_dp <= 1'b1;
      lp_dn <= 1'b1;
      busy <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= n_state;
      cnt <= n_cnt;
      idx <= n_idx;
      sh <= n_sh;
      last_f <= n_last;
      tb <= n_tb;
      byte_ready <= n_ready;
      hs_en <= n_hs_en;
      hs_bit <= n_hs_bit;
      lp_dp <= n_dp;
      lp_dn <= n_dn;
      busy <= n_busy;
      underrun <= n_ur;
    end
  end
endmodule

// File: tb/tb_dsi_hs_lane_tx.sv
// tb_dsi_hs_lane_tx: scenario model builds per-cycle stimulus/expected vectors; a compare process checks every cycle
module tb_dsi_hs_lane_tx;
  localparam int T_LPX = 2, T_PREP = 3, T_ZERO = 6, T_TRAIL = 4;
  // vector order: {hs_en, hs_bit, lp_dp, lp_dn, busy, underrun, byte_ready}
  localparam logic [6:0] IDLE_E = 7'b0011001;
  localparam logic [6:0] LPX_E  = 7'b0001100;
  localparam logic [6:0] PREP_E = 7'b0000100;
  localparam logic [6:0] ZERO_E = 7'b1000100;
  localparam logic [6:0] EXIT_E = 7'b0011100;
  localparam logic [6:0] RST_E  = 7'b0011000;
  typedef struct packed {logic v; logic [7:0] d; logic l; logic [6:0] e;} ent_t;
  logic dsi_clk = 0, rst = 1;
  logic [7:0] byte_data = 0;
  logic byte_valid = 0, byte_last = 0;
  logic byte_ready, hs_en, hs_bit, lp_dp, lp_dn, busy, underrun;
  ent_t sq[$];
  logic [6:0] eq[$];
  int total = 0, bad = 0, cyc = 0, hs_n = 0, ur_n = 0;
  logic [63:0] hs_log = 0;
  dsi_hs_lane_tx #(.T_LPX(T_LPX), .T_PREP(T_PREP), .T_ZERO(T_ZERO), .T_TRAIL(T_TRAIL), .CNT_W(8)) dut (
    .dsi_clk(dsi_clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .hs_en(hs_en), .hs_bit(hs_bit),
    .lp_dp(lp_dp), .lp_dn(lp_dn), .busy(busy), .underrun(underrun));
  always #5 dsi_clk = ~dsi_clk;
  function automatic logic [6:0] outs();
    return {hs_en, hs_bit, lp_dp, lp_dn, busy, underrun, byte_ready};
  endfunction
  always @(posedge dsi_clk) begin
    logic [6:0] e;
    #2;
    cyc++;
    if (hs_en === 1'b1) begin
      hs_log = {hs_log[62:0], hs_bit};
      hs_n++;
    end
    if (underrun === 1'b1) ur_n++;
    if (eq.size() != 0) begin
      e = eq.pop_front();
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL cycle%0d outs got=%b want=%b", cyc, outs(), e);
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic [6:0] e);
    sq.push_back('{v: v, d: d, l: l, e: e});
  endtask
  task automatic idle(input int n);
    repeat (n) add(1'b0, 8'h00, 1'b0, IDLE_E);
  endtask
  // expected lane behaviour for one burst of n bytes; ur: last never flagged and valid drops;
  // pend: a further byte (pd) is already offered during trail/exit/idle
  task automatic burst(input int n, input logic [7:0] b0, b1, b2, input bit ur, input bit pend,
                       input logic [7:0] pd);
    logic [7:0] b [3];
    logic [7:0] s;
    logic t;
    b[0] = b0; b[1] = b1; b[2] = b2; s = 8'hB8;
    add(1'b1, b[0], n == 1 && !ur, LPX_E);
    for (int i = 1; i < T_LPX; i++) add(1'b0, 8'h00, 1'b0, LPX_E);
    for (int i = 0; i < T_PREP; i++) add(1'b0, 8'h00, 1'b0, PREP_E);
    for (int i = 0; i < T_ZERO; i++) add(1'b0, 8'h00, 1'b0, ZERO_E);
    for (int j = 0; j < 8; j++) add(1'b0, 8'h00, 1'b0, {1'b1, s[j], 5'b00100});
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++)
        add(j == 0 && i > 0, b[i], i == n - 1 && !ur,
            {1'b1, b[i][j], 4'b0010, j == 7 && !(i == n - 1 && !ur)});
    t = ~b[n-1][7];
    for (int k = 0; k < T_TRAIL; k++) add(pend, pd, 1'b1, {1'b1, t, 3'b001, ur && k == 0, 1'b0});
    add(pend, pd, 1'b1, EXIT_E);
    add(pend, pd, 1'b1, IDLE_E);
  endtask
  task automatic play();
    ent_t e;
    while (sq.size() != 0) begin
      @(negedge dsi_clk);
      e = sq.pop_front();
      byte_valid = e.v;
      byte_data = e.d;
      byte_last = e.l;
      eq.push_back(e.e);
    end
  endtask
  task automatic clr();
    @(negedge dsi_clk);
    hs_log = 0;
    hs_n = 0;
    ur_n = 0;
  endtask
  initial begin
    @(negedge dsi_clk);
    chk("reset_outs", 64'(outs()), 64'(RST_E));
    @(negedge dsi_clk);
    rst = 0;
    idle(10);
    play();
    clr();
    burst(1, 8'hA5, 8'h00, 8'h00, 0, 0, 8'h00);
    idle(2);
    play();
    @(negedge dsi_clk);
    chk("a5_hs_bits", hs_log & 64'h3FFFFFF, 64'(26'b000000_00011101_10100101_0000));
    chk("a5_hs_cycles", 64'(hs_n), 64'd26);
    clr();
    burst(3, 8'h01, 8'h80, 8'hFF, 0, 0, 8'h00);
    idle(2);
    play();
    @(negedge dsi_clk);
    chk("burst3_hs_bits", hs_log & 64'h3FF_FFFFFFFF,
        64'(42'b000000_00011101_10000000_00000001_11111111_0000));
    chk("burst3_no_underrun", 64'(ur_n), 64'd0);
    clr();
    burst(2, 8'h0F, 8'h3C, 8'h00, 1, 0, 8'h00);
    idle(2);
    play();
    @(negedge dsi_clk);
    chk("underrun_hs_bits", hs_log & 64'h3F_FFFFFFFF,
        64'(38'b000000_00011101_11110000_00111100_1111));
    chk("underrun_pulses", 64'(ur_n), 64'd1);
    burst(1, 8'hC3, 8'h00, 8'h00, 0, 1, 8'h96);
    burst(1, 8'h96, 8'h00, 8'h00, 0, 0, 8'h00);
    idle(2);
    play();
    idle(2);
    burst(1, 8'h5A, 8'h00, 8'h00, 0, 0, 8'h00);
    while (sq.size() > 2 + T_LPX + T_PREP + T_ZERO + 8 + 4) void'(sq.pop_back());
    play();
    @(negedge dsi_clk);
    byte_valid = 0;
    rst = 1;
    #1;
    chk("rst_midburst", 64'(outs()), 64'(RST_E));
    @(negedge dsi_clk);
    chk("rst_held", 64'(outs()), 64'(RST_E));
    rst = 0;
    clr();
    idle(1);
    burst(1, 8'h33, 8'h00, 8'h00, 0, 0, 8'h00);
    idle(2);
    play();
    @(negedge dsi_clk);
    chk("post_rst_hs_bits", hs_log & 64'h3FFFFFF, 64'(26'b000000_00011101_11001100_1111));
    @(negedge dsi_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsi_hs_lane_tx.md
Name: dsi_hs_lane_tx

Overview:
- Per-lane D-PHY data-lane transmitter in the dsi_clk domain, directly downstream of the DSI clock generator.
- Accepts a byte stream from the packet assembler via a valid/ready handshake.
- Wraps the stream in the LP->HS entry sequence (LP-01, LP-00, HS-zero, sync 0xB8), serialises bytes LSB-first, then performs HS-trail and returns to LP-11.
- One instance per data lane.

Parameters:
- T_LPX, 2, cycles of LP-01 (≥1)
- T_PREP, 3, cycles of LP-00 HS-prepare (≥1)
- T_ZERO, 6, cycles of HS-zero (hs_en=1, hs_bit=0) (≥1)
- T_TRAIL, 4, cycles of HS-trail (≥1)
- CNT_W, 8, width of timing counter; each T_* must be < 2**CNT_W

Ports:
- dsi_clk  in  1  serial bit clock from the DSI clock generator
- rst  in  1  asynchronous active-high reset
- byte_data  in  8  payload byte
- byte_valid  in  1  byte_data/byte_last valid
- byte_last  in  1  marks final byte of the HS burst
- byte_ready  out  1  lane accepts byte this cycle (valid&ready = transfer)
- hs_en  out  1  HS driver enable
- hs_bit  out  1  HS serial data bit
- lp_dp  out  1  LP driver, Dp line
- lp_dn  out  1  LP driver, Dn line
- busy  out  1  high in every state except IDLE
- underrun  out  1  one-cycle pulse: stream starved mid-burst

Behaviour:
- All outputs registered, all updated on posedge dsi_clk.
- Reset values: hs_en=0, hs_bit=0, lp_dp=1, lp_dn=1, busy=0, underrun=0, byte_ready=0. State returns to IDLE.
- Reset asserted mid-burst aborts immediately, with no trail; outputs are forced to reset values asynchronously.
- FSM states are IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT.
- IDLE: LP-11, byte_ready=1. On valid&ready, latch byte_data/byte_last into shift register and go to LPX.
- LPX: lp=01 (dp=0, dn=1) for T_LPX cycles, then go to PREP.
- PREP: lp=00 for T_PREP cycles, then go to ZERO.
- ZERO: hs_en=1, hs_bit=0, lp=00 for T_ZERO cycles, then go to SYNC.
- SYNC: drive 0xB8 LSB-first (0,0,0,1,1,1,0,1), one bit per cycle, then go to DATA.
- DATA: drive shift register LSB-first over 8 cycles, using a 3-bit bit index.
  - On bit index 7, byte_ready=1 unless the current byte is last.
  - If a transfer occurs on bit 7, the new byte loads and its bit 0 goes out next cycle, with no gap.
  - Current byte last at bit 7 -> go to TRAIL.
  - Not last and byte_valid=0 at bit 7 -> go to TRAIL and pulse underrun for 1 cycle concurrently with the first TRAIL cycle.
- TRAIL: hs_en=1, hs_bit = inverse of last transmitted data bit, for T_TRAIL cycles, then go to EXIT.
- EXIT: hs_en=0, lp=11, one cycle, then go to IDLE.
- byte_ready is 0 in LPX, PREP, ZERO, TRAIL and EXIT, and in SYNC/DATA except as stated above.
  - byte_valid held during those states is not accepted.
  - The pending byte is taken in IDLE, after EXIT.
- Timing counter: reloads to 0 on each state entry; the exit condition is count == T_x-1.
- busy=1 from the cycle after IDLE acceptance until EXIT inclusive.
- lp outputs hold 00 during ZERO, SYNC, DATA and TRAIL.

Test Plan:
- Reset then idle 10 cycles -> lp=11, hs_en=0, byte_ready=1, busy=0 throughout.
- Defaults; single byte 0xA5 with last=1 in IDLE -> expected sequence, then IDLE:
  - LP-01 ×2, LP-00 ×3, then hs_en=1 with zeros ×6.
  - hs_bit 0,0,0,1,1,1,0,1 (sync), then 1,0,1,0,0,1,0,1 (data).
  - Trail 0 ×4, EXIT LP-11 ×1, IDLE.
- Bursts 0x01,0x80,0xFF (last on 0xFF), valid always high -> 24 contiguous data bits 1000000000000001 11111111; byte_ready high exactly at bit-7 of 0x01 and 0x80; trail bits=0.
- Bytes 0x0F,0x3C with last never asserted and valid dropped after 0x3C -> after 0x3C bit 7 (value 0) go to TRAIL with hs_bit=1 ×4; underrun pulses once, aligned with first TRAIL cycle.
- rst asserted at the 4th data bit of a burst -> same-cycle hs_en=0, lp=11, busy=0; after release, next byte starts a fresh LPX.
- byte_valid asserted during TRAIL of a previous burst -> no transfer until IDLE; byte accepted in the IDLE cycle after EXIT, new LPX follows.
